imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
//
// PURPOSE
//  Registered, handshaked immediate generator for the decode stage.
//  - Extracts and sign-extends the RV immediate for I/S/B/U/J formats to XLEN.
//  - Reports the format and flags unknown opcodes.
//  - Carries the instruction's PC as sideband.
//  - Sits between fetch and the register-read stage; a skid buffer lets
//    backpressure from execute stall fetch without losing instructions.
//
// PARAMETERS
//  XLEN    32  datapath width; immediate sign-extended from bit 31 of instr to XLEN (32 or 64)
//  SKID    1   1: 2-entry skid buffer (full throughput under stall); 0: single output register
//  U_EN    1   1: decode LUI/AUIPC as U-type; 0: treat them as unknown (zero imm, oIllegal=1)
//
// PORTS
//  iCLK         in   1     clock, rising edge
//  iRSTn        in   1     asynchronous active-low reset
//  iValid       in   1     iInstruction/iPC valid this cycle
//  oReady       out  1     block accepts input this cycle
//  iInstruction in   32    raw instruction word
//  iPC          in   XLEN  PC of iInstruction, passed through unchanged
//  oValid       out  1     output payload valid
//  iReady       in   1     downstream accepts output this cycle
//  oImmediate   out  XLEN  decoded immediate
//  oKind        out  3     0 none, 1 I, 2 S, 3 B, 4 U, 5 J
//  oIllegal     out  1     opcode not in decode table
//  oPC          out  XLEN  PC of the instruction on the output
//
// BEHAVIOUR
//  Decode (combinational on iInstruction[6:0]; s = instr[31], sign-extended to XLEN):
//  - LOAD 0000011, TIPOI 0010011, JALR 1100111 -> I: {s.., i[31:20]}
//  - STORE 0100011 -> S: {s.., i[31:25], i[11:7]}
//  - BRANCH 1100011 -> B: {s.., i[7], i[30:25], i[11:8], 0}
//  - JUMP 1101111 -> J: {s.., i[19:12], i[20], i[30:21], 0}
//  - LUI 0110111, AUIPC 0010111 (U_EN=1) -> U: {s.., i[31:12], 12'b0}
//  - TIPOR 0110011 -> kind 0, imm 0, not illegal
//  - anything else -> kind 0, imm 0, oIllegal=1
//  Handshake:
//  - Transfer on a side when valid & ready are both high at a rising edge.
//  - Latency is exactly 1 cycle, input accept to oValid, when the output is empty.
//  - Order is preserved; no drop, no duplication.
//  - Once oValid=1, the payload holds stable until it is accepted.
//  - oReady depends only on registered state (no combinational iReady->oReady path).
//  SKID=1 states:
//  - EMPTY: oValid=0, oReady=1. Accept -> FULL1.
//  - FULL1: oValid=1, oReady=1.
//    - Out & in together -> FULL1 with the new payload.
//    - Out only -> EMPTY.
//    - In only -> FULL2; the new item goes to the skid register.
//  - FULL2: oValid=1, oReady=0. Out -> FULL1; the skid item moves to the output.
//  SKID=0:
//  - oReady = !oValid, so at most one item is in flight.
//  - Throughput is 1 item per 2 cycles.
//  Reset (async assert, any state, mid-transfer included):
//  - oValid=0, oReady=1, oImmediate=0, oKind=0, oIllegal=0, oPC=0.
//  - Skid contents are discarded.
//  Other rules:
//  - iValid=0 with iReady=1 drains the block normally.
//  - Input payload is ignored when not accepted.
//
// TESTING
//  1. After reset: iValid=1, instr 0xFFF00093 (addi x1,x0,-1), iPC=0x100, iReady=1.
//     Next cycle: oValid=1, imm=0xFFFFFFFF, kind=1, oPC=0x100.
//  2. Stream 0xFE112E23 (sw, -4), 0x00000863 (beq, +16), 0x123452B7 (lui),
//     0x001000EF (jal, +2048) back-to-back with iReady=1.
//     Outputs on consecutive cycles: 0xFFFFFFFC/S, 0x00000010/B, 0x12345000/U, 0x00000800/J.
//  3. Hold iReady=0 while driving 3 inputs.
//     - SKID=1: oReady falls after 2 accepts; oValid payload stays stable.
//     - Raise iReady: both items emerge in order on 2 consecutive cycles, none lost.
//  4. Instr 0x0000007F -> imm 0, kind 0, oIllegal=1. With U_EN=0, 0x123452B7 -> oIllegal=1.
//  5. Assert iRSTn=0 mid-way through a FULL2 stall.
//     - Outputs clear immediately, without waiting for a clock edge.
//     - After release, only new inputs appear.
//  6. XLEN=64: 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF; 0x800002B7 (lui) -> 0xFFFFFFFF80000000.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV immediate decoder with valid/ready handshake.
// The output register is backed by an optional skid register so that a stall
// from execute can hold fetch off one cycle late without losing instructions.
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1,
    parameter bit U_EN = 1'b1
) (
    input  logic            iCLK,
    input  logic            iRSTn,
    input  logic            iValid,
    output logic            oReady,
    input  logic [31:0]     iInstruction,
    input  logic [XLEN-1:0] iPC,
    output logic            oValid,
    input  logic            iReady,
    output logic [XLEN-1:0] oImmediate,
    output logic [2:0]      oKind,
    output logic            oIllegal,
    output logic [XLEN-1:0] oPC
);

    localparam logic [2:0] K_NONE = 3'd0;
    localparam logic [2:0] K_I    = 3'd1;
    localparam logic [2:0] K_S    = 3'd2;
    localparam logic [2:0] K_B    = 3'd3;
    localparam logic [2:0] K_U    = 3'd4;
    localparam logic [2:0] K_J    = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      kind;
        logic            ill;
        logic [XLEN-1:0] pc;
    } pl_t;

    logic        [31:0] ins;
    logic               s;
    logic signed [31:0] imm32;
    pl_t                dec;
    pl_t                out_pl, skid_pl;
    logic               out_vld, skid_vld;
    logic               in_acc, out_acc;

    assign ins = iInstruction;
    assign s   = iInstruction[31];

    // Decode the opcode into a 32-bit immediate, then sign-extend to XLEN
    always_comb begin
        imm32    = '0;
        dec      = '0;
        dec.pc   = iPC;
        unique case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                dec.kind = K_I;
                imm32    = {{20{s}}, ins[31:20]};
            end
            7'b0100011: begin
                dec.kind = K_S;
                imm32    = {{20{s}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                dec.kind = K_B;
                imm32    = {{19{s}}, s, ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'b1101111: begin
                dec.kind = K_J;
                imm32    = {{11{s}}, s, ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                if (U_EN) begin
                    dec.kind = K_U;
                    imm32    = {ins[31:12], 12'b0};
                end else begin
                    dec.ill  = 1'b1;
                end
            end
            7'b0110011: begin
                dec.kind = K_NONE;
            end
            default: begin
                dec.ill  = 1'b1;
            end
        endcase
        // signed size cast replicates bit 31 up to XLEN
        dec.imm = XLEN'(imm32);
    end

    // Ready comes only from registered occupancy: skid free, or output free
    assign oReady  = SKID ? !skid_vld : !out_vld;
    assign in_acc  = iValid && oReady;
    assign out_acc = out_vld && iReady;

    // Output/skid occupancy: refill the output from skid first, then from input
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            out_pl   <= '0;
            skid_pl  <= '0;
        end else if (!out_vld || out_acc) begin
            if (skid_vld) begin
                out_pl   <= skid_pl;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else if (in_acc) begin
                out_pl   <= dec;
                out_vld  <= 1'b1;
            end else begin
                out_vld  <= 1'b0;
            end
        end else if (in_acc) begin
            // output stalled but still ready: only reachable with a skid
            skid_pl  <= dec;
            skid_vld <= 1'b1;
        end
    end

    assign oValid     = out_vld;
    assign oImmediate = out_pl.imm;
    assign oKind      = out_pl.kind;
    assign oIllegal   = out_pl.ill;
    assign oPC        = out_pl.pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a skid instance (XLEN=32) plus two SKID=0
// instances (XLEN=64 and U_EN=0) sharing one stimulus stream.
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  kind;
        logic        ill;
        logic [63:0] pc;
    } exp_t;

    logic gclk = 1'b0;
    logic grst_n;
    always #5 gclk = ~gclk;

    // instance A: defaults
    logic        a_vld, a_ordy, a_ovld, a_rdy, a_ill;
    logic [31:0] a_ins, a_pc, a_imm, a_opc;
    logic [2:0]  a_kind;
    // instances B (XLEN=64) and C (U_EN=0), both SKID=0, shared inputs
    logic        b_vld, b_ordy, b_ovld, b_ill, c_ordy, c_ovld, c_ill;
    logic        bc_rdy;
    logic [31:0] b_ins, c_imm, c_opc;
    logic [63:0] b_pc, b_imm, b_opc;
    logic [2:0]  b_kind, c_kind;

    imm_gen_pipe u_a (
        .iCLK(gclk), .iRSTn(grst_n), .iValid(a_vld), .oReady(a_ordy),
        .iInstruction(a_ins), .iPC(a_pc), .oValid(a_ovld), .iReady(a_rdy),
        .oImmediate(a_imm), .oKind(a_kind), .oIllegal(a_ill), .oPC(a_opc));

    imm_gen_pipe #(.XLEN(64), .SKID(1'b0), .U_EN(1'b1)) u_b (
        .iCLK(gclk), .iRSTn(grst_n), .iValid(b_vld), .oReady(b_ordy),
        .iInstruction(b_ins), .iPC(b_pc), .oValid(b_ovld), .iReady(bc_rdy),
        .oImmediate(b_imm), .oKind(b_kind), .oIllegal(b_ill), .oPC(b_opc));

    imm_gen_pipe #(.XLEN(32), .SKID(1'b0), .U_EN(1'b0)) u_c (
        .iCLK(gclk), .iRSTn(grst_n), .iValid(b_vld), .oReady(c_ordy),
        .iInstruction(b_ins), .iPC(b_pc[31:0]), .oValid(c_ovld), .iReady(bc_rdy),
        .oImmediate(c_imm), .oKind(c_kind), .oIllegal(c_ill), .oPC(c_opc));

    exp_t qa[$], qb[$], qc[$];
    int   n_chk = 0, n_fail = 0;
    int   a_pops = 0;
    logic        a_held_v = 1'b0;
    logic [131:0] a_held;

    function automatic exp_t mk(input logic [63:0] imm, input logic [2:0] kind,
                                input logic ill, input logic [63:0] pc);
        exp_t e;
        e.imm = imm; e.kind = kind; e.ill = ill; e.pc = pc;
        return e;
    endfunction

    function automatic logic [131:0] pk(input exp_t e);
        return {e.imm, e.kind, e.ill, e.pc};
    endfunction

    task automatic chk(input string nm, input logic [131:0] act, input logic [131:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [131:0] cur_a();
        return {32'b0, a_imm, a_kind, a_ill, 32'b0, a_opc};
    endfunction

    // Monitor A: pop/compare on each transfer, and check payload holds while stalled
    always @(negedge gclk) begin
        if (a_ovld) begin
            if (a_held_v) chk("a_hold", cur_a(), a_held);
            if (a_rdy) begin
                a_held_v = 1'b0;
                if (qa.size() == 0) fail_now("a_unexpected_output");
                else chk("a_out", cur_a(), pk(qa.pop_front()));
                a_pops++;
            end else begin
                a_held_v = 1'b1;
                a_held   = cur_a();
            end
        end else begin
            a_held_v = 1'b0;
        end
    end

    // Monitor B
    always @(negedge gclk) begin
        if (b_ovld && bc_rdy) begin
            if (qb.size() == 0) fail_now("b_unexpected_output");
            else chk("b_out", {b_imm, b_kind, b_ill, b_opc}, pk(qb.pop_front()));
        end
    end

    // Monitor C
    always @(negedge gclk) begin
        if (c_ovld && bc_rdy) begin
            if (qc.size() == 0) fail_now("c_unexpected_output");
            else chk("c_out", {32'b0, c_imm, c_kind, c_ill, 32'b0, c_opc}, pk(qc.pop_front()));
        end
    end

    // Drive one item into A; inputs change #1 after posedge, accept at next edge
    task automatic send_a(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
        a_vld = 1'b1; a_ins = ins; a_pc = pc;
        for (int n = 0; n < 50; n++) begin
            if (a_ordy) begin
                qa.push_back(e);
                @(posedge gclk); #1;
                a_vld = 1'b0;
                return;
            end
            @(posedge gclk); #1;
        end
        a_vld = 1'b0;
        fail_now("a_accept_timeout");
    endtask

    task automatic send_bc(input logic [31:0] ins, input logic [63:0] pc,
                           input exp_t eb, input exp_t ec);
        b_vld = 1'b1; b_ins = ins; b_pc = pc;
        for (int n = 0; n < 50; n++) begin
            if (b_ordy) begin
                chk("c_ready_match", {131'b0, c_ordy}, 132'd1);
                qb.push_back(eb);
                qc.push_back(ec);
                @(posedge gclk); #1;
                b_vld = 1'b0;
                return;
            end
            @(posedge gclk); #1;
        end
        b_vld = 1'b0;
        fail_now("bc_accept_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        grst_n = 1'b0;
        a_vld = 0; a_ins = '0; a_pc = '0; a_rdy = 1'b1;
        b_vld = 0; b_ins = '0; b_pc = '0; bc_rdy = 1'b1;
        repeat (2) @(posedge gclk);
        #1;
        chk("rst_a_hs", {130'b0, a_ovld, a_ordy}, 132'b01);
        chk("rst_a_pl", cur_a(), 132'b0);
        chk("rst_b", {b_ovld, b_ordy, b_imm, b_kind, b_ill, b_opc}, {2'b01, 132'b0});
        grst_n = 1'b1;
        @(posedge gclk); #1;

        // 1: first item after reset, latency 1
        send_a(32'hFFF00093, 32'h100, mk(64'hFFFFFFFF, 3'd1, 1'b0, 64'h100));
        chk("t1_latency", {131'b0, a_ovld}, 132'd1);
        @(posedge gclk); #1;

        // 2: back-to-back stream, one output per cycle
        p0 = a_pops;
        send_a(32'hFE112E23, 32'h104, mk(64'hFFFFFFFC, 3'd2, 1'b0, 64'h104));
        send_a(32'h00000863, 32'h108, mk(64'h00000010, 3'd3, 1'b0, 64'h108));
        send_a(32'h123452B7, 32'h10C, mk(64'h12345000, 3'd4, 1'b0, 64'h10C));
        send_a(32'h001000EF, 32'h110, mk(64'h00000800, 3'd5, 1'b0, 64'h110));
        @(posedge gclk); #1;
        chk("t2_throughput", 132'(a_pops - p0), 132'd4);

        // 3: stall with 3 inputs offered; skid absorbs 2
        a_rdy = 1'b0;
        send_a(32'hFFF00093, 32'h200, mk(64'hFFFFFFFF, 3'd1, 1'b0, 64'h200));
        chk("t3_ready_full1", {131'b0, a_ordy}, 132'd1);
        send_a(32'h00000863, 32'h204, mk(64'h00000010, 3'd3, 1'b0, 64'h204));
        a_vld = 1'b1; a_ins = 32'hFE112E23; a_pc = 32'h208;
        for (int i = 0; i < 3; i++) begin
            chk("t3_ready_full2", {131'b0, a_ordy}, 132'd0);
            @(posedge gclk); #1;
        end
        a_rdy = 1'b1;
        p0 = a_pops;
        send_a(32'hFE112E23, 32'h208, mk(64'hFFFFFFFC, 3'd2, 1'b0, 64'h208));
        chk("t3_drain_two", 132'(a_pops - p0), 132'd2);
        repeat (2) @(posedge gclk); #1;

        // 4: unknown opcode and register-register op
        send_a(32'h0000007F, 32'h300, mk(64'h0, 3'd0, 1'b1, 64'h300));
        send_a(32'h00B50533, 32'h304, mk(64'h0, 3'd0, 1'b0, 64'h304));

        // 4/6: XLEN=64 and U_EN=0 instances
        send_bc(32'hFFF00093, 64'h80000000_00001000,
                mk(64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0, 64'h80000000_00001000),
                mk(64'hFFFFFFFF, 3'd1, 1'b0, 64'h1000));
        send_bc(32'h800002B7, 64'h2000,
                mk(64'hFFFFFFFF_80000000, 3'd4, 1'b0, 64'h2000),
                mk(64'h0, 3'd0, 1'b1, 64'h2000));
        send_bc(32'h123452B7, 64'h2004,
                mk(64'h12345000, 3'd4, 1'b0, 64'h2004),
                mk(64'h0, 3'd0, 1'b1, 64'h2004));
        send_bc(32'h001000EF, 64'h2008,
                mk(64'h800, 3'd5, 1'b0, 64'h2008),
                mk(64'h800, 3'd5, 1'b0, 64'h2008));
        repeat (3) @(posedge gclk); #1;

        // 5: async reset in the middle of a FULL2 stall
        a_rdy = 1'b0;
        send_a(32'hFFF00093, 32'h400, mk(64'hFFFFFFFF, 3'd1, 1'b0, 64'h400));
        send_a(32'h00000863, 32'h404, mk(64'h10, 3'd3, 1'b0, 64'h404));
        chk("t5_full2", {130'b0, a_ovld, a_ordy}, 132'b10);
        #2;
        grst_n = 1'b0;
        #1;
        chk("t5_async_hs", {130'b0, a_ovld, a_ordy}, 132'b01);
        chk("t5_async_pl", cur_a(), 132'b0);
        qa.delete();
        @(posedge gclk); #1;
        grst_n = 1'b1;
        a_rdy = 1'b1;
        @(posedge gclk); #1;
        chk("t5_no_stale", {130'b0, a_ovld, a_ordy}, 132'b01);
        send_a(32'h123452B7, 32'h500, mk(64'h12345000, 3'd4, 1'b0, 64'h500));
        repeat (3) @(posedge gclk); #1;

        chk("a_queue_empty", 132'(qa.size()), 132'd0);
        chk("b_queue_empty", 132'(qb.size()), 132'd0);
        chk("c_queue_empty", 132'(qc.size()), 132'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
